// File: rtl/mskaes_job_sched.sv
// Round-robin job scheduler sharing one masked AES-128 core between NREQ requesters.
// Optional MSKAES_SCHED_CYCCNT_EN adds rsp_cycles, the BUSY-cycle count of each job.
module mskaes_job_sched #(
    parameter int d    = 2,
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128*d-1:0] req_sh_plaintext,
    input  logic [NREQ*128*d-1:0] req_sh_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [128*d-1:0]      rsp_sh_ciphertext,
`ifdef MSKAES_SCHED_CYCCNT_EN
    output logic [15:0]           rsp_cycles,
`endif
    input  logic                  prng_ready,
    input  logic                  core_ready,
    output logic                  core_valid_in,
    input  logic                  core_cipher_valid,
    output logic [128*d-1:0]      core_sh_plaintext,
    output logic [128*d-1:0]      core_sh_key,
    input  logic [128*d-1:0]      core_sh_ciphertext,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and data stable until then and the consumer never retracts ready.
    localparam int W = 128 * d;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_pt;
    logic [W-1:0]   r_key;
    logic [W-1:0]   r_ct;
    logic           r_rsp_valid;

    logic           w_found_hi;
    logic           w_found_lo;
    logic [IDW-1:0] w_idx_hi;
    logic [IDW-1:0] w_idx_lo;
    logic           w_gnt_found;
    logic [IDW-1:0] w_gnt_idx;
    logic [NREQ-1:0] w_gnt_oh;
    logic [W-1:0]   w_sel_pt;
    logic [W-1:0]   w_sel_key;
    logic           w_go;

    // Round-robin: prefer the lowest requester above the pointer, else wrap to the lowest at/below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (i > int'(r_ptr)) begin
                    if (!w_found_hi) begin
                        w_found_hi = 1'b1;
                        w_idx_hi   = IDW'(i);
                    end
                end else if (!w_found_lo) begin
                    w_found_lo = 1'b1;
                    w_idx_lo   = IDW'(i);
                end
            end
        end
        w_gnt_found = w_found_hi | w_found_lo;
        w_gnt_idx   = w_found_hi ? w_idx_hi : w_idx_lo;
    end

    always_comb begin
        w_gnt_oh  = '0;
        w_sel_pt  = '0;
        w_sel_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_gnt_idx) begin
                w_gnt_oh[i] = w_gnt_found;
                w_sel_pt    = req_sh_plaintext[i*W +: W];
                w_sel_key   = req_sh_key[i*W +: W];
            end
        end
    end

    assign w_go      = (r_state == S_IDLE) && core_ready && prng_ready && w_gnt_found;
    assign req_ready = w_go ? w_gnt_oh : '0;

    always_comb begin
        w_next        = r_state;
        core_valid_in = 1'b0;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_ISSUE;
            S_ISSUE: begin
                core_valid_in = 1'b1;
                w_next        = S_BUSY;
            end
            S_BUSY:  if (core_cipher_valid) w_next = S_HOLD;
            S_HOLD:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_pt        <= '0;
            r_key       <= '0;
            r_ct        <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_pt  <= w_sel_pt;
                r_key <= w_sel_key;
                r_id  <= w_gnt_idx;
                r_ptr <= w_gnt_idx;
            end
            if (r_state == S_BUSY && core_cipher_valid) begin
                r_ct        <= core_sh_ciphertext;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == S_HOLD && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef MSKAES_SCHED_CYCCNT_EN
    logic [15:0] r_cnt;
    logic [15:0] r_rsp_cycles;

    // The captured value includes the BUSY cycle in which the core reports done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt        <= '0;
            r_rsp_cycles <= '0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_BUSY && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == S_BUSY && core_cipher_valid) begin
                r_rsp_cycles <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            end
        end
    end

    assign rsp_cycles = r_rsp_cycles;
`endif

    assign rsp_valid         = r_rsp_valid;
    assign rsp_id            = r_id;
    assign rsp_sh_ciphertext = r_ct;
    assign core_sh_plaintext = r_pt;
    assign core_sh_key       = r_key;
    assign dbg_state         = r_state;

endmodule

// File: doc/mskaes_job_sched.md
Name: mskaes_job_sched

Overview:
- Round-robin scheduler that shares one masked AES-128 core (MSKaes_128bits) between NREQ requesters.
- Grants one job at a time, latches the requester's shared plaintext/key, issues a single-cycle start to the core and waits for cipher_valid.
- Captures the shared ciphertext and returns it with the requester ID over a valid/ready response channel.
- Sits between the system bus adapters and the AES core. Randomness buses go straight to the core; this block only gates start on a PRNG-ready flag.

Parameters:
- d, 2, number of shares; all data buses are 128*d bits, share-interleaved per bit as in the core.
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_sh_plaintext  in  NREQ*128*d  shared plaintexts; requester i at slice [i*128*d +: 128*d].
- req_sh_key  in  NREQ*128*d  shared keys, same slicing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_sh_ciphertext  out  128*d  captured shared ciphertext.
- prng_ready  in  1  randomness source seeded/valid; no job starts while low.
- core_ready  in  1  core ready flag.
- core_valid_in  out  1  core start pulse.
- core_cipher_valid  in  1  core done flag.
- core_sh_plaintext  out  128*d  to core.
- core_sh_key  out  128*d  to core.
- core_sh_ciphertext  in  128*d  from core.

Behaviour:
- Reset (async, nrst=0): state=IDLE; req_ready=0, core_valid_in=0, rsp_valid=0, rsp_id=0, rsp_sh_ciphertext=0, latched plaintext/key=0, rr pointer=NREQ-1. The core shares nrst, so reset mid-job aborts the job silently.
- FSM states:
  - IDLE: when core_ready & prng_ready & |req_valid, grant the first i with req_valid[i], searching (ptr+1) mod NREQ upward with wrap. Assert req_ready[i] combinationally in that cycle. On the clock edge, latch the plaintext/key slices and set id=i, ptr=i, then go to ISSUE. With no request, or with either gate low, stay in IDLE with req_ready=0.
  - ISSUE: core_valid_in=1 for exactly one cycle, then go to BUSY.
  - BUSY: wait for core_cipher_valid. On that edge, capture core_sh_ciphertext into rsp_sh_ciphertext, set rsp_valid=1, and go to HOLD.
  - HOLD: hold rsp_valid, rsp_id and data stable until rsp_valid & rsp_ready, then clear rsp_valid and go to IDLE.
- core_sh_plaintext/core_sh_key are driven from the latches only, so they are stable from ISSUE through BUSY regardless of requester input changes.
- Simultaneous requests are granted in round-robin order; a requester held valid is never starved beyond NREQ-1 other jobs.
- req_valid deasserting in the grant cycle is not legal for requesters. The grant decision uses the current-cycle value.
- core_cipher_valid outside BUSY is ignored. prng_ready dropping after grant does not abort the job.
- Latency: grant edge -> ISSUE 1 cycle; core done -> rsp_valid 1 cycle.
- Shares are never recombined inside the block. No logic mixes shares; the block is routing and registers only.

Optional Feature:
- Macro MSKAES_SCHED_CYCCNT_EN.
- When defined: add output rsp_cycles (16 bits). A counter clears to 0 in ISSUE and increments each BUSY cycle, saturating at 16'hFFFF. Its value is captured with the ciphertext and held with rsp_valid. Reset value is 0.
- When undefined: the port and counter are absent.

Test Plan:
- Single job, requester 0: key 128'h3c4fcf098815f7aba6d2ae2816157e2b, plaintext 128'h340737e0a29831318d305a88a8f64332, both shared with d=2. Expected: req_ready[0] pulses once, core_valid_in is high for exactly 1 cycle, rsp_valid rises 1 cycle after core_cipher_valid, rsp_id=0, recombined ciphertext = 128'h320b6a19978511dcfb09dc021d842539.
- Both requesters valid from reset with the same vector: grants go 0 then 1, two responses with rsp_id 0 then 1, each carrying 128'h320b...2539. req_ready is never high for both requesters in the same cycle.
- prng_ready=0 with requests pending: no req_ready and no core_valid_in for 20 cycles. Raise prng_ready: grant on the next cycle.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid. rsp_valid, rsp_id and data stay stable, no new grant is issued, and the job completes one cycle after rsp_ready=1.
- Requester changes req_sh_key to all-ones during BUSY: core_sh_key is unchanged and the result is still 128'h320b...2539.
- Assert nrst=0 mid-BUSY: all outputs return to reset values immediately. After release, a new job completes correctly. With MSKAES_SCHED_CYCCNT_EN, rsp_cycles equals the number of BUSY cycles observed.
